// File: rtl/spi_flash_op_arbiter.sv
// rtl/spi_flash_op_arbiter.sv - round-robin arbiter sharing one SPI flash driver between two requesters
// The grant is held from request capture until the driver signals completion or the low timeout expires.
module spi_flash_op_arbiter #(
  parameter int P_LOW_TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,

  input  logic [1:0]  i_a_operation_type,
  input  logic [23:0] i_a_operation_addr,
  input  logic [8:0]  i_a_operation_num,
  input  logic        i_a_operation_valid,
  output logic        o_a_operation_ready,
  input  logic [7:0]  i_a_write_data,
  input  logic        i_a_write_sop,
  input  logic        i_a_write_eop,
  input  logic        i_a_write_valid,
  output logic [7:0]  o_a_read_data,
  output logic        o_a_read_sop,
  output logic        o_a_read_eop,
  output logic        o_a_read_valid,

  input  logic [1:0]  i_b_operation_type,
  input  logic [23:0] i_b_operation_addr,
  input  logic [8:0]  i_b_operation_num,
  input  logic        i_b_operation_valid,
  output logic        o_b_operation_ready,
  input  logic [7:0]  i_b_write_data,
  input  logic        i_b_write_sop,
  input  logic        i_b_write_eop,
  input  logic        i_b_write_valid,
  output logic [7:0]  o_b_read_data,
  output logic        o_b_read_sop,
  output logic        o_b_read_eop,
  output logic        o_b_read_valid,

  output logic [1:0]  o_operation_type,
  output logic [23:0] o_operation_addr,
  output logic [8:0]  o_operation_num,
  output logic        o_operation_valid,
  input  logic        i_operation_ready,

  output logic [7:0]  o_write_data,
  output logic        o_write_sop,
  output logic        o_write_eop,
  output logic        o_write_valid,
  input  logic [7:0]  i_read_data,
  input  logic        i_read_sop,
  input  logic        i_read_eop,
  input  logic        i_read_valid,

  output logic [1:0]  o_grant,
  output logic        o_busy
);

  localparam int CW = (P_LOW_TIMEOUT > 1) ? $clog2(P_LOW_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_LOW,
    S_WAIT_HIGH
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic        last_b_q, last_b_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]  op_type_q, op_type_d;
  logic [23:0] op_addr_q, op_addr_d;
  logic [8:0]  op_num_q, op_num_d;
  logic        op_valid_q, op_valid_d;
  logic        a_rdy_q, a_rdy_d;
  logic        b_rdy_q, b_rdy_d;
  logic        pick_b;

  // B wins when it is the only requester, or on a tie when A was served last.
  assign pick_b = i_b_operation_valid & (~i_a_operation_valid | ~last_b_q);

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_b_d   = last_b_q;
    cnt_d      = cnt_q;
    op_type_d  = op_type_q;
    op_addr_d  = op_addr_q;
    op_num_d   = op_num_q;
    op_valid_d = op_valid_q;
    a_rdy_d    = 1'b0;
    b_rdy_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_a_operation_valid || i_b_operation_valid) begin
          state_d    = S_ISSUE;
          op_valid_d = 1'b1;
          last_b_d   = pick_b;
          if (pick_b) begin
            grant_d   = 2'b10;
            b_rdy_d   = 1'b1;
            op_type_d = i_b_operation_type;
            op_addr_d = i_b_operation_addr;
            op_num_d  = i_b_operation_num;
          end else begin
            grant_d   = 2'b01;
            a_rdy_d   = 1'b1;
            op_type_d = i_a_operation_type;
            op_addr_d = i_a_operation_addr;
            op_num_d  = i_a_operation_num;
          end
        end
      end
      S_ISSUE: begin
        if (op_valid_q && i_operation_ready) begin
          op_valid_d = 1'b0;
          cnt_d      = '0;
          state_d    = S_WAIT_LOW;
        end
      end
      S_WAIT_LOW: begin
        // A driver that never drops ready would otherwise lock the grant forever.
        if (!i_operation_ready) begin
          state_d = S_WAIT_HIGH;
        end else if (cnt_q == CW'(P_LOW_TIMEOUT - 1)) begin
          state_d = S_IDLE;
          grant_d = 2'b00;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_HIGH: begin
        if (i_operation_ready) begin
          state_d = S_IDLE;
          grant_d = 2'b00;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      grant_q    <= 2'b00;
      last_b_q   <= 1'b1;
      cnt_q      <= '0;
      op_type_q  <= '0;
      op_addr_q  <= '0;
      op_num_q   <= '0;
      op_valid_q <= 1'b0;
      a_rdy_q    <= 1'b0;
      b_rdy_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_b_q   <= last_b_d;
      cnt_q      <= cnt_d;
      op_type_q  <= op_type_d;
      op_addr_q  <= op_addr_d;
      op_num_q   <= op_num_d;
      op_valid_q <= op_valid_d;
      a_rdy_q    <= a_rdy_d;
      b_rdy_q    <= b_rdy_d;
    end
  end

  assign o_operation_type    = op_type_q;
  assign o_operation_addr    = op_addr_q;
  assign o_operation_num     = op_num_q;
  assign o_operation_valid   = op_valid_q;
  assign o_a_operation_ready = a_rdy_q;
  assign o_b_operation_ready = b_rdy_q;
  assign o_grant             = grant_q;
  assign o_busy              = (state_q != S_IDLE);

  // Stream routing is purely combinational on the registered grant.
  always_comb begin
    o_write_data   = '0;
    o_write_sop    = 1'b0;
    o_write_eop    = 1'b0;
    o_write_valid  = 1'b0;
    o_a_read_data  = '0;
    o_a_read_sop   = 1'b0;
    o_a_read_eop   = 1'b0;
    o_a_read_valid = 1'b0;
    o_b_read_data  = '0;
    o_b_read_sop   = 1'b0;
    o_b_read_eop   = 1'b0;
    o_b_read_valid = 1'b0;
    if (grant_q[0]) begin
      o_write_data   = i_a_write_data;
      o_write_sop    = i_a_write_sop;
      o_write_eop    = i_a_write_eop;
      o_write_valid  = i_a_write_valid;
      o_a_read_data  = i_read_data;
      o_a_read_sop   = i_read_sop;
      o_a_read_eop   = i_read_eop;
      o_a_read_valid = i_read_valid;
    end else if (grant_q[1]) begin
      o_write_data   = i_b_write_data;
      o_write_sop    = i_b_write_sop;
      o_write_eop    = i_b_write_eop;
      o_write_valid  = i_b_write_valid;
      o_b_read_data  = i_read_data;
      o_b_read_sop   = i_read_sop;
      o_b_read_eop   = i_read_eop;
      o_b_read_valid = i_read_valid;
    end
  end

endmodule

// File: tb/tb_spi_flash_op_arbiter.sv
// tb/tb_spi_flash_op_arbiter.sv - directed and randomized checks of spi_flash_op_arbiter against a transaction model
module tb_spi_flash_op_arbiter;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] a_type = '0, b_type = '0;
  logic [23:0] a_addr = '0, b_addr = '0;
  logic [8:0] a_num = '0, b_num = '0;
  logic a_valid = 1'b0, b_valid = 1'b0;
  logic a_rdy, b_rdy;
  logic [7:0] a_wdata = '0, b_wdata = '0;
  logic a_wsop = 1'b0, a_weop = 1'b0, a_wvalid = 1'b0;
  logic b_wsop = 1'b0, b_weop = 1'b0, b_wvalid = 1'b0;
  logic [7:0] a_rdata, b_rdata;
  logic a_rsop, a_reop, a_rvalid, b_rsop, b_reop, b_rvalid;
  logic [1:0] op_type;
  logic [23:0] op_addr;
  logic [8:0] op_num;
  logic op_valid;
  logic op_ready = 1'b1;
  logic [7:0] wdata;
  logic wsop, weop, wvalid;
  logic [7:0] rdata = '0;
  logic rsop = 1'b0, reop = 1'b0, rvalid = 1'b0;
  logic [1:0] grant;
  logic busy;

  int n_cmp = 0;
  int n_err = 0;

  spi_flash_op_arbiter #(.P_LOW_TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_a_operation_type(a_type), .i_a_operation_addr(a_addr), .i_a_operation_num(a_num),
    .i_a_operation_valid(a_valid), .o_a_operation_ready(a_rdy),
    .i_a_write_data(a_wdata), .i_a_write_sop(a_wsop), .i_a_write_eop(a_weop), .i_a_write_valid(a_wvalid),
    .o_a_read_data(a_rdata), .o_a_read_sop(a_rsop), .o_a_read_eop(a_reop), .o_a_read_valid(a_rvalid),
    .i_b_operation_type(b_type), .i_b_operation_addr(b_addr), .i_b_operation_num(b_num),
    .i_b_operation_valid(b_valid), .o_b_operation_ready(b_rdy),
    .i_b_write_data(b_wdata), .i_b_write_sop(b_wsop), .i_b_write_eop(b_weop), .i_b_write_valid(b_wvalid),
    .o_b_read_data(b_rdata), .o_b_read_sop(b_rsop), .o_b_read_eop(b_reop), .o_b_read_valid(b_rvalid),
    .o_operation_type(op_type), .o_operation_addr(op_addr), .o_operation_num(op_num),
    .o_operation_valid(op_valid), .i_operation_ready(op_ready),
    .o_write_data(wdata), .o_write_sop(wsop), .o_write_eop(weop), .o_write_valid(wvalid),
    .i_read_data(rdata), .i_read_sop(rsop), .i_read_eop(reop), .i_read_valid(rvalid),
    .o_grant(grant), .o_busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction model: who owns the driver, whether the command was taken,
  // and how the driver's ready has behaved since.
  int m_owner = 0;
  bit m_last_b = 1'b1;
  bit m_accepted = 1'b0;
  bit m_dropped = 1'b0;
  int m_run = 0;
  bit m_rdy_a = 1'b0, m_rdy_b = 1'b0;
  logic [1:0] m_type = '0;
  logic [23:0] m_addr = '0;
  logic [8:0] m_num = '0;
  int m_win;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = 0; m_last_b = 1'b1; m_accepted = 1'b0; m_dropped = 1'b0; m_run = 0;
      m_rdy_a = 1'b0; m_rdy_b = 1'b0; m_type = '0; m_addr = '0; m_num = '0;
    end else begin
      m_rdy_a = 1'b0;
      m_rdy_b = 1'b0;
      if (m_owner == 0) begin
        if (a_valid || b_valid) begin
          if (a_valid && b_valid) m_win = m_last_b ? 1 : 2;
          else m_win = a_valid ? 1 : 2;
          m_owner = m_win;
          m_last_b = (m_win == 2);
          m_accepted = 1'b0;
          if (m_win == 1) begin
            m_rdy_a = 1'b1; m_type = a_type; m_addr = a_addr; m_num = a_num;
          end else begin
            m_rdy_b = 1'b1; m_type = b_type; m_addr = b_addr; m_num = b_num;
          end
        end
      end else if (!m_accepted) begin
        if (op_ready) begin
          m_accepted = 1'b1; m_run = 0; m_dropped = 1'b0;
        end
      end else if (!m_dropped) begin
        if (!op_ready) m_dropped = 1'b1;
        else begin
          m_run++;
          if (m_run == TO) m_owner = 0;
        end
      end else if (op_ready) begin
        m_owner = 0;
      end
    end
  end

  logic [10:0] e_w, e_ra, e_rb;
  always @(negedge clk) begin
    e_w  = (m_owner == 1) ? {a_wdata, a_wsop, a_weop, a_wvalid} :
           (m_owner == 2) ? {b_wdata, b_wsop, b_weop, b_wvalid} : 11'd0;
    e_ra = (m_owner == 1) ? {rdata, rsop, reop, rvalid} : 11'd0;
    e_rb = (m_owner == 2) ? {rdata, rsop, reop, rvalid} : 11'd0;
    check("grant", grant, (m_owner == 1) ? 2'b01 : (m_owner == 2) ? 2'b10 : 2'b00);
    check("busy", busy, m_owner != 0);
    check("op_valid", op_valid, (m_owner != 0) && !m_accepted);
    check("a_ready", a_rdy, m_rdy_a);
    check("b_ready", b_rdy, m_rdy_b);
    check("op_fields", {op_type, op_addr, op_num}, {m_type, m_addr, m_num});
    check("write_mux", {wdata, wsop, weop, wvalid}, e_w);
    check("a_read", {a_rdata, a_rsop, a_reop, a_rvalid}, e_ra);
    check("b_read", {b_rdata, b_rsop, b_reop, b_rvalid}, e_rb);
  end

  task automatic next();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input string nm);
    int c = 0;
    while (busy && c < 60) begin
      next();
      c++;
    end
    check(nm, busy, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    next();
    next();
    rst_n = 1'b1;
    next();
  endtask

  logic [1:0] exp_ord [3] = '{2'b01, 2'b10, 2'b01};
  int drv_cnt = 0;

  initial begin
    int cnt, bc, gap, rv, sops, eop_at, a_rv, wleak, c;
    do_reset();
    check("reset_grant", grant, 2'b00);
    check("reset_busy", busy, 1'b0);
    check("reset_op_valid", op_valid, 1'b0);
    check("reset_a_ready", a_rdy, 1'b0);

    // A writes 256 bytes at address 256
    op_ready = 1'b1;
    a_valid = 1'b1; a_type = 2'd1; a_addr = 24'd256; a_num = 9'd256;
    next();
    check("t2_a_ready", a_rdy, 1'b1);
    check("t2_op_valid", op_valid, 1'b1);
    check("t2_type", op_type, 2'd1);
    check("t2_addr", op_addr, 24'd256);
    check("t2_num", op_num, 9'd256);
    check("t2_grant", grant, 2'b01);
    a_valid = 1'b0;
    next();
    check("t2_ready_pulse_end", a_rdy, 1'b0);
    check("t2_accepted", op_valid, 1'b0);
    op_ready = 1'b0;
    cnt = 0;
    for (int i = 0; i < 256; i++) begin
      a_wdata = 8'(i); a_wsop = (i == 0); a_weop = (i == 255); a_wvalid = 1'b1;
      #1;
      if (wvalid && wdata == 8'(i) && wsop == (i == 0) && weop == (i == 255)) cnt++;
      next();
    end
    a_wvalid = 1'b0; a_wsop = 1'b0; a_weop = 1'b0;
    check("t2_write_bytes", cnt, 256);
    op_ready = 1'b1;
    wait_idle("t2_release");
    check("t2_grant_released", grant, 2'b00);

    // ties after reset alternate A, B, A; driver never drops ready
    do_reset();
    op_ready = 1'b1;
    a_valid = 1'b1; a_type = 2'd2; a_addr = 24'h000100; a_num = 9'd4;
    b_valid = 1'b1; b_type = 2'd1; b_addr = 24'h000200; b_num = 9'd8;
    for (int k = 0; k < 3; k++) begin
      gap = 0;
      while (grant == 2'b00 && gap < 40) begin
        next();
        gap++;
      end
      check("tie_order", grant, exp_ord[k]);
      if (k == 1) check("idle_gap", gap, 1);
      bc = 0;
      while (busy && bc < 100) begin
        bc++;
        next();
      end
      if (k == 0) check("timeout_busy_cycles", bc, TO + 1);
    end
    a_valid = 1'b0; b_valid = 1'b0;
    wait_idle("t3_idle");

    // B reads 256 bytes while A toggles its write stream
    b_valid = 1'b1; b_type = 2'd2; b_addr = 24'h123456; b_num = 9'd256;
    next();
    check("t4_grant", grant, 2'b10);
    b_valid = 1'b0;
    next();
    op_ready = 1'b0;
    rv = 0; sops = 0; eop_at = -1; a_rv = 0; wleak = 0;
    for (int i = 0; i < 256; i++) begin
      rdata = 8'($urandom); rsop = (i == 0); reop = (i == 255); rvalid = 1'b1;
      a_wdata = 8'($urandom); a_wvalid = 1'($urandom); a_wsop = 1'($urandom); a_weop = 1'($urandom);
      #1;
      if (b_rvalid && b_rdata == rdata) rv++;
      if (b_rsop) sops++;
      if (b_reop) eop_at = i;
      if (a_rvalid) a_rv++;
      if (wvalid) wleak++;
      next();
    end
    rvalid = 1'b0; rsop = 1'b0; reop = 1'b0;
    a_wvalid = 1'b0; a_wsop = 1'b0; a_weop = 1'b0;
    check("t4_read_bytes", rv, 256);
    check("t4_sop_count", sops, 1);
    check("t4_eop_index", eop_at, 255);
    check("t4_a_read_quiet", a_rv, 0);
    check("t4_a_write_blocked", wleak, 0);
    op_ready = 1'b1;
    wait_idle("t4_release");

    // reset while waiting for the driver to finish
    a_valid = 1'b1; a_type = 2'd1; a_addr = 24'hABCDEF; a_num = 9'd3;
    next();
    a_valid = 1'b0;
    next();
    op_ready = 1'b0;
    next();
    next();
    check("t6_busy_before", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("t6_grant", grant, 2'b00);
    check("t6_busy", busy, 1'b0);
    check("t6_addr", op_addr, 24'd0);
    check("t6_op_valid", op_valid, 1'b0);
    next();
    rst_n = 1'b1;
    op_ready = 1'b1;
    a_valid = 1'b1; b_valid = 1'b1;
    next();
    check("t6_tie_after_reset", grant, 2'b01);
    a_valid = 1'b0; b_valid = 1'b0;
    wait_idle("t6_idle");

    // random traffic, checked every cycle by the model
    for (int t = 0; t < 3000; t++) begin
      if (a_valid && a_rdy) a_valid = 1'($urandom);
      else if (!a_valid) a_valid = ($urandom_range(0, 3) == 0);
      if (a_valid && (a_rdy || t == 0)) begin
        a_type = 2'($urandom_range(0, 2)); a_addr = 24'($urandom); a_num = 9'($urandom);
      end
      if (b_valid && b_rdy) b_valid = 1'($urandom);
      else if (!b_valid) b_valid = ($urandom_range(0, 3) == 0);
      if (b_valid && (b_rdy || t == 0)) begin
        b_type = 2'($urandom_range(0, 2)); b_addr = 24'($urandom); b_num = 9'($urandom);
      end
      if (drv_cnt == 0) begin
        if ($urandom_range(0, 3) != 0) begin
          op_ready = 1'b1; drv_cnt = $urandom_range(1, 24);
        end else begin
          op_ready = 1'b0; drv_cnt = $urandom_range(1, 6);
        end
      end else drv_cnt--;
      {a_wdata, a_wsop, a_weop, a_wvalid} = 11'($urandom);
      {b_wdata, b_wsop, b_weop, b_wvalid} = 11'($urandom);
      {rdata, rsop, reop, rvalid} = 11'($urandom);
      next();
    end
    a_valid = 1'b0; b_valid = 1'b0; op_ready = 1'b1;
    c = 0;
    while (busy && c < 60) begin
      next();
      c++;
    end
    check("final_idle", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spi_flash_op_arbiter.md
# spi_flash_op_arbiter

Two-port arbiter sharing one SPI flash driver between two user requesters (A, B). Each requester issues operations (clear/write/read) with a valid/ready handshake and streams write/read data. The arbiter grants one requester at a time round-robin, forwards its operation to the driver, and holds the grant until the driver finishes. It routes the write stream from the granted requester and the read stream back to it. Sits between user logic and the flash driver.

## Interface
Parameters:
- P_LOW_TIMEOUT, 16: cycles to wait for driver ready to drop after acceptance before forcing release.

Ports (x = a, b; one set per requester):
- i_clk  input  1  clock; all logic on rising edge
- i_rst_n  input  1  asynchronous, active-low reset
- i_x_operation_type  input  2  0 clear, 1 write, 2 read
- i_x_operation_addr  input  24  flash address
- i_x_operation_num  input  9  byte count
- i_x_operation_valid  input  1  request; held with fields until ready seen
- o_x_operation_ready  output  1  one-cycle accept pulse
- i_x_write_data / i_x_write_sop / i_x_write_eop / i_x_write_valid  input  8/1/1/1  write stream
- o_x_read_data / o_x_read_sop / o_x_read_eop / o_x_read_valid  output  8/1/1/1  read stream
- o_operation_type / o_operation_addr / o_operation_num  output  2/24/9  to driver, registered
- o_operation_valid  output  1  to driver, registered
- i_operation_ready  input  1  driver ready; low while driver busy
- o_write_data / o_write_sop / o_write_eop / o_write_valid  output  8/1/1/1  to driver
- i_read_data / i_read_sop / i_read_eop / i_read_valid  input  8/1/1/1  from driver
- o_grant  output  2  one-hot {b,a}; 00 when idle
- o_busy  output  1  high in any state other than IDLE

## Operation
- States: IDLE, ISSUE, WAIT_LOW, WAIT_HIGH.
- IDLE: if any i_x_operation_valid, choose winner: single requester wins; both -> the one not served last (r_last_grant). Edge: capture winner fields into o_operation_*, o_operation_valid<=1, o_x_operation_ready<=1 (winner only, one cycle), o_grant<=winner, r_last_grant<=winner, go ISSUE.
- ISSUE: when o_operation_valid & i_operation_ready: o_operation_valid<=0, timeout counter cleared, go WAIT_LOW. Upstream valids ignored.
- WAIT_LOW: i_operation_ready==0 -> WAIT_HIGH; else counter+1; counter reaching P_LOW_TIMEOUT-1 -> IDLE (release).
- WAIT_HIGH: i_operation_ready==1 -> IDLE, o_grant<=00.
- Write mux: o_write_* = granted requester's i_x_write_* while o_grant!=0; all zero otherwise. Non-granted write input is dropped.
- Read demux: i_read_* copied to granted o_x_read_*; non-granted o_x_read_* all zero; with o_grant==0 all read outputs zero.
- o_operation_type/addr/num hold last captured value outside IDLE transitions.

## Timing
- Reset (async, i_rst_n low): state IDLE, all outputs 0, o_grant=00, r_last_grant=B (so A wins first tie), counter 0.
- Request visible at edge N in IDLE -> o_x_operation_ready and o_operation_valid high after edge N (cycle N+1). Ready pulse exactly one cycle.
- Driver accepts same cycle ready & valid high; o_operation_valid low next cycle.
- Release: one cycle after i_operation_ready seen high in WAIT_HIGH, back to IDLE; next arbitration earliest following edge (min one IDLE cycle between operations).
- Requester still asserting valid at the cycle after its ready pulse is not re-granted until IDLE is re-entered; it is treated as a new request.
- Simultaneous requests in IDLE: strict alternation under continuous load (A,B,A,B...).
- Write/read mux paths combinational on o_grant (zero added latency).
- Reset mid-operation: everything returns to reset values immediately; in-flight stream discarded.

## Test plan
- Reset then A requests write addr 256 num 256: o_a_operation_ready one-cycle pulse, o_operation_type=1, addr=256, num=256, o_grant=01; 256 write bytes pass to driver; release after driver ready rises.
- A and B both valid at same cycle after reset: A granted first, B granted at next IDLE; third tie goes to A.
- B read of 256 bytes: i_read_* appears on o_b_read_* with sop on first, eop on byte 256; o_a_read_valid stays 0.
- Driver holds ready high after acceptance (never drops): arbiter returns to IDLE after P_LOW_TIMEOUT=16 cycles in WAIT_LOW, o_grant=00.
- A's write stream toggled while B granted: o_write_valid follows B only; A data never reaches driver.
- i_rst_n pulsed low during WAIT_HIGH: all outputs 0 immediately, next tie grants A.
